// File: rtl/pulse_peak_detector.sv
// Pulse-height analyser stage. It sits after the shaping filter and watches the
// signed sample stream. For each pulse it records the maximum, the timestamp of
// that maximum, the pulse width and a pile-up flag. Each record is held in a
// single holding register and delivered over a valid/ready handshake. A record
// that arrives while the holding register is still full is counted as a drop.
module pulse_peak_detector #(
   parameter int DATA_W    = 16,
   parameter int TS_W      = 32,
   parameter int WIDTH_W   = 8,
   parameter int HOLDOFF   = 8,
   parameter int MAX_WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic signed [DATA_W-1:0] threshold,
   input  logic signed [DATA_W-1:0] filter_data,
   output logic                     peak_valid,
   input  logic                     peak_ready,
   output logic signed [DATA_W-1:0] peak_amp,
   output logic [TS_W-1:0]          peak_time,
   output logic [WIDTH_W-1:0]       peak_width,
   output logic                     pile_up,
   output logic [15:0]              drop_count
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ARMED = 2'd1;
   localparam logic [1:0] DEAD  = 2'd2;

   // The dead-time counter counts down from HOLDOFF-1. The FSM leaves DEAD on
   // the edge that sees zero, so exactly HOLDOFF samples are ignored.
   localparam int                  DEAD_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [DEAD_W-1:0]   DEAD_LOAD = DEAD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
   localparam logic [WIDTH_W-1:0]  WIDTH_SAT = '1;

   logic [1:0]               state_reg, state_next;
   logic [TS_W-1:0]          ts_reg;
   logic [DEAD_W-1:0]        dead_cnt_reg, dead_cnt_next;
   logic signed [DATA_W-1:0] max_reg, max_next;
   logic [TS_W-1:0]          max_ts_reg, max_ts_next;
   logic [WIDTH_W-1:0]       width_reg, width_next;

   logic                     valid_reg;
   logic signed [DATA_W-1:0] amp_reg;
   logic [TS_W-1:0]          time_reg;
   logic [WIDTH_W-1:0]       pwidth_reg;
   logic                     pile_reg;
   logic [15:0]              drop_reg;

   logic                     at_or_above;
   logic                     event_done;
   logic [31:0]              width_ext;
   logic                     width_over;

   assign at_or_above = (filter_data >= threshold);
   // A pulse completes on the first below-threshold sample. This only counts
   // while detection is still enabled; otherwise the pulse is aborted.
   assign event_done  = (state_reg == ARMED) && enable && !at_or_above;
   assign width_ext   = 32'(width_reg);
   assign width_over  = (width_ext > 32'(MAX_WIDTH));

   // Free-running timestamp. It keeps counting whether or not detection is enabled.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ts_reg <= '0;
      end else begin
         ts_reg <= ts_reg + TS_W'(1);
      end
   end

   // Next-state logic: trigger, peak tracking and dead time.
   always_comb begin
      state_next    = state_reg;
      dead_cnt_next = dead_cnt_reg;
      max_next      = max_reg;
      max_ts_next   = max_ts_reg;
      width_next    = width_reg;
      case (state_reg)
         IDLE: begin
            if (enable && at_or_above) begin
               state_next  = ARMED;
               max_next    = filter_data;
               max_ts_next = ts_reg;
               width_next  = WIDTH_W'(1);
            end
         end
         ARMED: begin
            if (!enable) begin
               state_next = IDLE;
            end else if (at_or_above) begin
               // Strictly greater, so that on a tie the earliest timestamp is kept.
               if (filter_data > max_reg) begin
                  max_next    = filter_data;
                  max_ts_next = ts_reg;
               end
               if (width_reg != WIDTH_SAT) begin
                  width_next = width_reg + WIDTH_W'(1);
               end
            end else if (HOLDOFF > 0) begin
               state_next    = DEAD;
               dead_cnt_next = DEAD_LOAD;
            end else begin
               state_next = IDLE;
            end
         end
         DEAD: begin
            if (!enable || dead_cnt_reg == '0) begin
               state_next = IDLE;
            end else begin
               dead_cnt_next = dead_cnt_reg - DEAD_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Registered state for the detector FSM and the peak tracker.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg    <= IDLE;
         dead_cnt_reg <= '0;
         max_reg      <= '0;
         max_ts_reg   <= '0;
         width_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         dead_cnt_reg <= dead_cnt_next;
         max_reg      <= max_next;
         max_ts_reg   <= max_ts_next;
         width_reg    <= width_next;
      end
   end

   // One-record holding register with a saturating drop counter. A slot freed
   // by a handshake on the same edge can take the new record immediately.
   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_reg  <= 1'b0;
         amp_reg    <= '0;
         time_reg   <= '0;
         pwidth_reg <= '0;
         pile_reg   <= 1'b0;
         drop_reg   <= '0;
      end else if (event_done) begin
         if (!valid_reg || peak_ready) begin
            valid_reg  <= 1'b1;
            amp_reg    <= max_reg;
            time_reg   <= max_ts_reg;
            pwidth_reg <= width_reg;
            pile_reg   <= width_over;
         end else if (drop_reg != 16'hFFFF) begin
            drop_reg <= drop_reg + 16'd1;
         end
      end else if (valid_reg && peak_ready) begin
         valid_reg <= 1'b0;
      end
   end

   assign peak_valid = valid_reg;
   assign peak_amp   = amp_reg;
   assign peak_time  = time_reg;
   assign peak_width = pwidth_reg;
   assign pile_up    = pile_reg;
   assign drop_count = drop_reg;

endmodule
